// File: rtl/data_memory_line.sv
// Line-granular backing memory for the data cache: one 256-bit line read or
// write per request, fixed LATENCY cycles to a single-cycle acknowledge.
module data_memory_line #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 10
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  addr_i,
  input  logic [255:0] data_i,
  input  logic         enable_i,
  input  logic         write_i,
  output logic         ack_o,
  output logic [255:0] data_o
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ACK  = 2'd2
  } state_e;

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [IDX_W-1:0]   idx_q;
  logic               wr_q;
  logic [255:0]       wdata_q;
  logic               ack_q;
  logic [255:0]       rdata_q;

  logic [255:0]       memory [DEPTH];

  logic               commit_s;
  logic [IDX_W-1:0]   commit_idx_s;
  logic               commit_wr_s;
  logic [255:0]       commit_data_s;
  logic               unused_addr_s;

  assign unused_addr_s = ^{addr_i[31:IDX_W+5], addr_i[4:0]};

  // With LATENCY of one the access commits on the accepting edge, so the
  // request fields come straight from the inputs instead of the capture regs.
  always_comb begin
    commit_s      = 1'b0;
    commit_idx_s  = idx_q;
    commit_wr_s   = wr_q;
    commit_data_s = wdata_q;
    case (state_q)
      ST_IDLE: begin
        if (enable_i && (LATENCY == 1)) begin
          commit_s      = 1'b1;
          commit_idx_s  = addr_i[IDX_W+4:5];
          commit_wr_s   = write_i;
          commit_data_s = data_i;
        end else begin
          commit_s      = 1'b0;
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_W'(1)) begin
          commit_s = 1'b1;
        end else begin
          commit_s = 1'b0;
        end
      end
      default: commit_s = 1'b0;
    endcase
  end

  // Request sequencing, acknowledge and read-data registers.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      wr_q    <= 1'b0;
      wdata_q <= 256'h0;
      ack_q   <= 1'b0;
      rdata_q <= 256'h0;
    end else begin
      ack_q <= 1'b0;
      if (commit_s && !commit_wr_s) begin
        rdata_q <= memory[commit_idx_s];
      end
      case (state_q)
        ST_IDLE: begin
          if (enable_i) begin
            idx_q   <= addr_i[IDX_W+4:5];
            wr_q    <= write_i;
            wdata_q <= data_i;
            cnt_q   <= CNT_W'(LATENCY - 1);
            if (commit_s) begin
              state_q <= ST_ACK;
              ack_q   <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_q - CNT_W'(1);
          if (commit_s) begin
            state_q <= ST_ACK;
            ack_q   <= 1'b1;
          end
        end
        ST_ACK:  state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Storage is never reset; a write abandoned by reset must not land.
  always_ff @(posedge clk_i) begin
    if (rst_i && commit_s && commit_wr_s) begin
      memory[commit_idx_s] <= commit_data_s;
    end
  end

  assign ack_o  = ack_q;
  assign data_o = rdata_q;

endmodule
